sr_latch_array: RTL and testbench

- Parametrised, clocked successor to the single-bit LUT SR latch: a bank of WIDTH set/reset state bits in one clock domain.
- Each channel has an optional input synchroniser, optional edge-triggered set and a selectable conflict-resolution mode.
- A per-channel clear request/acknowledge handshake lets a consumer retire captured events.
- Summary outputs (any, lowest pending index) let it serve as an event/interrupt capture bank between asynchronous producers and synchronous control logic.

---
 rtl/sr_latch_pkg.sv | 20 ++
 rtl/sr_sync.sv | 31 +++
 rtl/sr_latch_array.sv | 129 ++++++++++++
 tb/tb_sr_latch_array.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types and helpers for the clocked SR latch bank.
package sr_latch_pkg;

  // How a channel resolves set and reset asserted in the same cycle.
  typedef enum logic [1:0] {
    SR_RST_DOM = 2'd0,
    SR_SET_DOM = 2'd1,
    SR_TOGGLE  = 2'd2,
    SR_HOLD    = 2'd3
  } sr_mode_e;

  localparam int unsigned MAX_WIDTH       = 64;
  localparam int unsigned MAX_SYNC_STAGES = 3;

  // Index width for a bank of n channels; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_sync.sv
// Multi-stage flop synchroniser for a vector of independent bits.
// STAGES=0 degenerates to a wire so raw inputs can be used directly.
module sr_sync #(
  parameter int unsigned      WIDTH  = 1,
  parameter int unsigned      STAGES = 2,
  parameter logic [WIDTH-1:0] RVAL   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_sync
    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < int'(STAGES); i++) stg[i] <= RVAL;
      end else begin
        stg[0] <= d;
        for (int i = 1; i < int'(STAGES); i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[STAGES-1];
  end

endmodule

// File: rtl/sr_latch_array.sv
// Bank of clocked set/reset state bits with synchronised inputs, optional
// edge-triggered set, per-channel clear handshake and pending summary.
module sr_latch_array
  import sr_latch_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RVAL        = '0,
  parameter logic [WIDTH-1:0] SET_INV     = '0,
  parameter logic [WIDTH-1:0] RESET_INV   = '0,
  parameter sr_mode_e         MODE        = SR_RST_DOM,
  parameter logic             EDGE        = 1'b0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             set,
  input  logic [WIDTH-1:0]             reset,
  input  logic                         clr_req,
  input  logic [idx_width(WIDTH)-1:0]  clr_idx,
  output logic                         clr_ack,
  output logic                         clr_err,
  output logic [WIDTH-1:0]             o,
  output logic [WIDTH-1:0]             o_n,
  output logic                         any,
  output logic [idx_width(WIDTH)-1:0]  first_idx
);

  localparam int unsigned    IDXW    = idx_width(WIDTH);
  localparam logic [IDXW:0]  WIDTH_L = (IDXW+1)'(WIDTH);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_param
    $error("sr_latch_array: WIDTH or SYNC_STAGES out of range");
  end

  logic [WIDTH-1:0] s_sync;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] r_eff;
  logic [WIDTH-1:0] s_prev;
  logic [WIDTH-1:0] s_use;
  logic [WIDTH-1:0] r_use;
  logic [WIDTH-1:0] o_nxt;
  logic             idx_ok;
  logic             clr_hit;
  logic             clr_bad;

  // Synchronisers idle at the raw level that reads as inactive after inversion.
  sr_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES),
    .RVAL   (SET_INV)
  ) u_sync_set (
    .clk (clk),
    .rst (rst),
    .d   (set),
    .q   (s_sync)
  );

  sr_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES),
    .RVAL   (RESET_INV)
  ) u_sync_reset (
    .clk (clk),
    .rst (rst),
    .d   (reset),
    .q   (r_sync)
  );

  assign s_eff = s_sync ^ SET_INV;
  assign r_eff = r_sync ^ RESET_INV;
  assign s_use = EDGE ? (s_eff & ~s_prev) : s_eff;
  assign r_use = r_eff;

  assign idx_ok  = {1'b0, clr_idx} < WIDTH_L;
  assign clr_hit = clr_req & idx_ok;
  assign clr_bad = clr_req & ~idx_ok;

  // Per-channel next state; a clear never beats a same-cycle set event.
  always_comb begin
    o_nxt = o;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({s_use[i], r_use[i]})
        2'b10:   o_nxt[i] = 1'b1;
        2'b01:   o_nxt[i] = 1'b0;
        2'b11: begin
          case (MODE)
            SR_RST_DOM: o_nxt[i] = 1'b0;
            SR_SET_DOM: o_nxt[i] = 1'b1;
            SR_TOGGLE:  o_nxt[i] = ~o[i];
            default:    o_nxt[i] = o[i];
          endcase
        end
        default: o_nxt[i] = o[i];
      endcase
      if (clr_hit && (clr_idx == IDXW'(i)) && !s_use[i]) begin
        o_nxt[i] = 1'b0;
      end
    end
  end

  // Edge history resets high so an input already active at release is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o       <= RVAL;
      o_n     <= ~RVAL;
      s_prev  <= '1;
      clr_ack <= 1'b0;
      clr_err <= 1'b0;
    end else begin
      o       <= o_nxt;
      o_n     <= ~o_nxt;
      s_prev  <= s_eff;
      clr_ack <= clr_hit;
      clr_err <= clr_bad;
    end
  end

  assign any = |o;

  // Lowest pending index wins.
  always_comb begin
    first_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (o[i]) first_idx = IDXW'(i);
    end
  end

endmodule

// File: tb/tb_sr_latch_array.sv
// Directed checks of sr_latch_array across several parameter sets.
module tb_sr_latch_array;
  import sr_latch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Reset-dominant bank, 2-stage sync, RVAL=A5
  logic [7:0] rd_set, rd_reset, rd_o, rd_on;
  logic       rd_req, rd_ack, rd_err, rd_any;
  logic [2:0] rd_idx, rd_first;
  // Toggle and hold banks sharing one stimulus, no sync
  logic [7:0] tg_set, tg_reset, tg_o, tg_on, hd_o, hd_on;
  logic       tg_req, tg_ack, tg_err, tg_any, hd_ack, hd_err, hd_any;
  logic [2:0] tg_idx, tg_first, hd_first;
  // Edge-triggered, inverted set[0], set-dominant, 12 channels, 1-stage sync
  logic [11:0] ed_set, ed_reset, ed_o, ed_on;
  logic        ed_req, ed_ack, ed_err, ed_any;
  logic [3:0]  ed_idx, ed_first;

  sr_latch_array #(.WIDTH(8), .RVAL(8'hA5), .MODE(SR_RST_DOM), .EDGE(1'b0), .SYNC_STAGES(2)) u_rd (
    .clk(clk), .rst(rst), .set(rd_set), .reset(rd_reset), .clr_req(rd_req), .clr_idx(rd_idx),
    .clr_ack(rd_ack), .clr_err(rd_err), .o(rd_o), .o_n(rd_on), .any(rd_any), .first_idx(rd_first));

  sr_latch_array #(.WIDTH(8), .MODE(SR_TOGGLE), .SYNC_STAGES(0)) u_tg (
    .clk(clk), .rst(rst), .set(tg_set), .reset(tg_reset), .clr_req(tg_req), .clr_idx(tg_idx),
    .clr_ack(tg_ack), .clr_err(tg_err), .o(tg_o), .o_n(tg_on), .any(tg_any), .first_idx(tg_first));

  sr_latch_array #(.WIDTH(8), .MODE(SR_HOLD), .SYNC_STAGES(0)) u_hd (
    .clk(clk), .rst(rst), .set(tg_set), .reset(tg_reset), .clr_req(tg_req), .clr_idx(tg_idx),
    .clr_ack(hd_ack), .clr_err(hd_err), .o(hd_o), .o_n(hd_on), .any(hd_any), .first_idx(hd_first));

  sr_latch_array #(.WIDTH(12), .SET_INV(12'h001), .MODE(SR_SET_DOM), .EDGE(1'b1), .SYNC_STAGES(1)) u_ed (
    .clk(clk), .rst(rst), .set(ed_set), .reset(ed_reset), .clr_req(ed_req), .clr_idx(ed_idx),
    .clr_ack(ed_ack), .clr_err(ed_err), .o(ed_o), .o_n(ed_on), .any(ed_any), .first_idx(ed_first));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_set = '0; rd_reset = '0; rd_req = 1'b0; rd_idx = '0;
    tg_set = '0; tg_reset = '0; tg_req = 1'b0; tg_idx = '0;
    ed_set = 12'h001; ed_reset = '0; ed_req = 1'b0; ed_idx = '0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (rd_o !== 8'hA5 || rd_on !== 8'h5A) begin
      miscompares++; $display("FAIL reset_o: o=%h o_n=%h expected A5/5A", rd_o, rd_on);
    end
    vectors++;
    if (rd_any !== 1'b1 || rd_first !== 3'd0 || rd_ack !== 1'b0 || rd_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_summary: any=%b first=%0d ack=%b err=%b expected 1/0/0/0", rd_any, rd_first, rd_ack, rd_err);
    end
    vectors++;
    if (ed_o !== 12'h000 || ed_on !== 12'hFFF || ed_any !== 1'b0) begin
      miscompares++; $display("FAIL reset_ed: o=%h o_n=%h any=%b expected 000/FFF/0", ed_o, ed_on, ed_any);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step();
    vectors++;
    if (rd_o !== 8'hA5 || tg_o !== 8'h00) begin
      miscompares++; $display("FAIL reset_release: rd_o=%h tg_o=%h expected A5/00", rd_o, tg_o);
    end
  endtask

  task automatic test_sync_latency();
    logic [7:0] exp_o [6] = '{8'hA5, 8'hA5, 8'hAD, 8'hAD, 8'hAD, 8'hA5};
    rd_set = 8'h08;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) rd_reset = 8'h08;
      step();
      vectors++;
      if (rd_o !== exp_o[i]) begin
        miscompares++; $display("FAIL sync_latency[%0d]: o=%h expected %h", i, rd_o, exp_o[i]);
      end
    end
    rd_set = '0; rd_reset = '0;
    repeat (3) step();
    vectors++;
    if (rd_o !== 8'hA5 || rd_on !== 8'h5A) begin
      miscompares++; $display("FAIL sync_drain: o=%h o_n=%h expected A5/5A", rd_o, rd_on);
    end
  endtask

  task automatic test_toggle_hold();
    logic [7:0] exp_tg [4] = '{8'h02, 8'h00, 8'h02, 8'h00};
    tg_set = 8'h02; tg_reset = 8'h02;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (tg_o !== exp_tg[i] || hd_o !== 8'h00) begin
        miscompares++; $display("FAIL toggle_hold[%0d]: tg=%h hd=%h expected %h/00", i, tg_o, hd_o, exp_tg[i]);
      end
    end
    tg_reset = 8'h00;
    step();
    vectors++;
    if (tg_o !== 8'h02 || hd_o !== 8'h02 || hd_first !== 3'd1) begin
      miscompares++; $display("FAIL set_only: tg=%h hd=%h first=%0d expected 02/02/1", tg_o, hd_o, hd_first);
    end
    tg_reset = 8'h02;
    step();
    vectors++;
    if (tg_o !== 8'h00 || hd_o !== 8'h02) begin
      miscompares++; $display("FAIL conflict_from_1: tg=%h hd=%h expected 00/02", tg_o, hd_o);
    end
    tg_set = 8'h00;
    step();
    vectors++;
    if (tg_o !== 8'h00 || hd_o !== 8'h00 || hd_any !== 1'b0) begin
      miscompares++; $display("FAIL reset_only: tg=%h hd=%h any=%b expected 00/00/0", tg_o, hd_o, hd_any);
    end
    tg_reset = 8'h00;
  endtask

  task automatic test_priority();
    rd_set = 8'h28; rd_reset = 8'hD7;
    repeat (3) step();
    rd_set = '0; rd_reset = '0;
    repeat (3) step();
    vectors++;
    if (rd_o !== 8'h28 || rd_on !== 8'hD7 || rd_any !== 1'b1 || rd_first !== 3'd3) begin
      miscompares++; $display("FAIL prio_load: o=%h o_n=%h any=%b first=%0d expected 28/D7/1/3", rd_o, rd_on, rd_any, rd_first);
    end
    rd_req = 1'b1; rd_idx = 3'd3;
    step();
    vectors++;
    if (rd_o !== 8'h20 || rd_ack !== 1'b1 || rd_err !== 1'b0 || rd_first !== 3'd5) begin
      miscompares++; $display("FAIL clear3: o=%h ack=%b err=%b first=%0d expected 20/1/0/5", rd_o, rd_ack, rd_err, rd_first);
    end
    rd_idx = 3'd5;
    step();
    vectors++;
    if (rd_o !== 8'h00 || rd_ack !== 1'b1 || rd_any !== 1'b0 || rd_first !== 3'd0) begin
      miscompares++; $display("FAIL clear5_b2b: o=%h ack=%b any=%b first=%0d expected 00/1/0/0", rd_o, rd_ack, rd_any, rd_first);
    end
    rd_req = 1'b0;
    step();
    vectors++;
    if (rd_ack !== 1'b0 || rd_err !== 1'b0) begin
      miscompares++; $display("FAIL ack_one_cycle: ack=%b err=%b expected 0/0", rd_ack, rd_err);
    end
  endtask

  task automatic test_clear_vs_set();
    rd_set = 8'h04;
    repeat (3) step();
    vectors++;
    if (rd_o !== 8'h04 || rd_first !== 3'd2) begin
      miscompares++; $display("FAIL set2: o=%h first=%0d expected 04/2", rd_o, rd_first);
    end
    rd_req = 1'b1; rd_idx = 3'd2;
    step();
    vectors++;
    if (rd_o !== 8'h04 || rd_ack !== 1'b1) begin
      miscompares++; $display("FAIL clear_loses_to_set: o=%h ack=%b expected 04/1", rd_o, rd_ack);
    end
    rd_req = 1'b0; rd_set = '0;
    repeat (3) step();
    rd_req = 1'b1;
    step();
    vectors++;
    if (rd_o !== 8'h00 || rd_ack !== 1'b1) begin
      miscompares++; $display("FAIL clear2_idle: o=%h ack=%b expected 00/1", rd_o, rd_ack);
    end
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_edge();
    logic [11:0] exp_o [5] = '{12'h000, 12'h001, 12'h000, 12'h000, 12'h000};
    ed_set = 12'h000;
    for (int i = 0; i < 5; i++) begin
      ed_req = (i == 2); ed_idx = 4'd0;
      step();
      vectors++;
      if (ed_o !== exp_o[i] || ed_ack !== (i == 2)) begin
        miscompares++; $display("FAIL edge_set[%0d]: o=%h ack=%b expected %h/%b", i, ed_o, ed_ack, exp_o[i], (i == 2));
      end
    end
    ed_req = 1'b0; ed_set = 12'h001;
    step();
    ed_set = 12'h011; ed_reset = 12'h010;
    step();
    vectors++;
    if (ed_o !== 12'h000) begin
      miscompares++; $display("FAIL setdom_e1: o=%h expected 000", ed_o);
    end
    step();
    vectors++;
    if (ed_o !== 12'h010 || ed_first !== 4'd4 || ed_any !== 1'b1) begin
      miscompares++; $display("FAIL setdom_conflict: o=%h first=%0d any=%b expected 010/4/1", ed_o, ed_first, ed_any);
    end
    step();
    vectors++;
    if (ed_o !== 12'h000) begin
      miscompares++; $display("FAIL edge_no_reset_mask: o=%h expected 000", ed_o);
    end
    ed_set = 12'h001; ed_reset = '0;
    repeat (2) step();
  endtask

  task automatic test_clr_err();
    logic [3:0] idx_tab [4] = '{4'd13, 4'd2, 4'd11, 4'd12};
    logic       err_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      ed_req = 1'b1; ed_idx = idx_tab[i];
      step();
      vectors++;
      if (ed_err !== err_tab[i] || ed_ack !== !err_tab[i] || ed_o !== 12'h000) begin
        miscompares++; $display("FAIL clr_err[%0d]: err=%b ack=%b o=%h expected %b/%b/000", i, ed_err, ed_ack, ed_o, err_tab[i], !err_tab[i]);
      end
    end
    ed_req = 1'b0;
    step();
    vectors++;
    if (ed_err !== 1'b0 || ed_ack !== 1'b0) begin
      miscompares++; $display("FAIL clr_err_idle: err=%b ack=%b expected 0/0", ed_err, ed_ack);
    end
  endtask

  task automatic test_reset_drops_ack();
    rd_req = 1'b1; rd_idx = 3'd0;
    step();
    vectors++;
    if (rd_ack !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_ack: ack=%b expected 1", rd_ack);
    end
    rd_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (rd_ack !== 1'b0 || rd_o !== 8'hA5 || rd_any !== 1'b1) begin
      miscompares++; $display("FAIL ack_dropped: ack=%b o=%h any=%b expected 0/A5/1", rd_ack, rd_o, rd_any);
    end
    @(negedge clk) rst = 1'b1;
    step();
    rd_req = 1'b1;
    @(negedge clk) rst = 1'b0;
    step();
    rd_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
    vectors++;
    if (rd_ack !== 1'b0 || rd_err !== 1'b0) begin
      miscompares++; $display("FAIL no_ack_after_reset: ack=%b err=%b expected 0/0", rd_ack, rd_err);
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_toggle_hold();
    test_priority();
    test_clear_vs_set();
    test_edge();
    test_clr_err();
    test_reset_drops_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
